mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter DATA_WIDTH SHALL be provided: default 8; width of operands, MAC data bus and result words.
REQ-002 Parameter LEN_WIDTH SHALL be provided: default 8; width of the vector-length input.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low, with ports named clk and a_reset_n.
REQ-004 Ports SHALL be, in order (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- a_reset_n  in  1  async active-low reset.
- start  in  1  begin dot product; sampled in IDLE only.
- length  in  LEN_WIDTH  element count; captured with start.
- a_data  in  DATA_WIDTH  operand A of current element.
- b_data  in  DATA_WIDTH  operand B of current element.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts pair.
- mac_opcode  out  4  opcode to MAC stage.
- mac_data  out  DATA_WIDTH  data to MAC stage.
- mac_result  in  DATA_WIDTH  MAC registered data_out.
- mac_overflow  in  1  MAC accumulator bit 2*DATA_WIDTH.
- busy  out  1  high in any state except IDLE.
- result_msw  out  DATA_WIDTH  captured accumulator upper word.
- result_lsw  out  DATA_WIDTH  captured accumulator lower word.
- overflow  out  1  captured mac_overflow.
- result_valid  out  1  one-cycle pulse: results updated.

Function
REQ-005 Opcodes SHALL be: RESET 0x0, MULT 0x1, ACC 0x2, REGA 0x4, REGB 0x5, MSW 0x6, LSW 0x7, NOOP 0xF; NOOP is driven in IDLE, DONE and every wait cycle (never 0x0 when idle).
REQ-006 FSM states SHALL be IDLE, CLR, LOAD_A, LOAD_B, MULT, ACC, RD_MSW, RD_LSW, CAP, DONE.
REQ-007 IDLE -> CLR when start=1; length captured into a down-counter; start in other states is ignored.
REQ-008 CLR: opcode RESET; -> LOAD_A if length!=0, else -> RD_MSW.
REQ-009 LOAD_A: in_ready=1; on in_valid=1: opcode REGA, mac_data=a_data, b_data latched internally, -> LOAD_B; on in_valid=0: opcode NOOP, stay.
REQ-010 LOAD_B: opcode REGB, mac_data=latched b_data; MULT: opcode MULT; ACC: opcode ACC, counter decrements; -> LOAD_A if remaining count>0, else -> RD_MSW.
REQ-011 RD_MSW: opcode MSW; RD_LSW: opcode LSW, result_msw<=mac_result; CAP: opcode NOOP, result_lsw<=mac_result, overflow<=mac_overflow; DONE: result_valid=1, -> IDLE.
REQ-012 in_ready SHALL be high only in LOAD_A; mac_data SHALL be 0 when not carrying operand data.
REQ-013 Latency with no stalls: start sampled at edge 0, result_valid high in cycle 4*length+5; each in_valid stall cycle adds one cycle.
REQ-014 result_msw/result_lsw/overflow SHALL hold until overwritten by the next CAP.

Reset
REQ-015 On a_reset_n=0, immediately: state IDLE, mac_opcode 0xF, mac_data 0, in_ready 0, busy 0, result_valid 0, result_msw 0, result_lsw 0, overflow 0, counter 0; reset mid-run abandons the run with no result_valid.

Configuration
REQ-016 With macro MAC_SEQ_ABORT_EN defined, input port abort (1 bit) SHALL exist; abort=1 in any non-IDLE state forces IDLE on the next edge with opcode NOOP and no result_valid; results unchanged.
REQ-017 Without MAC_SEQ_ABORT_EN, the abort port SHALL not exist and runs always complete.

Structure
REQ-018 MAC opcode constants and FSM state encoding SHALL live in shared package mac_pkg, also used by mac.
REQ-019 No sub-module: counter and FSM inline.

Verification (DATA_WIDTH=8)
REQ-020 length=1, (3,5) -> result_msw=0x00, result_lsw=0x0F, overflow=0, result_valid one cycle at cycle 9.
REQ-021 length=3, (255,255)x3 -> result_msw=0xFA, result_lsw=0x03, overflow=1.
REQ-022 length=2, (2,4) then 5 stall cycles then (6,7) -> opcode 0xF during stall, result 0x0032, result_valid at cycle 18.
REQ-023 length=0 -> opcode sequence 0x0, 0x6, 0x7, 0xF; result 0x0000; result_valid at cycle 5.
REQ-024 start pulsed while busy -> ignored; a_reset_n low mid-element -> opcode 0xF at once, busy 0; following length=1 (3,5) run -> 0x000F.
REQ-025 With MAC_SEQ_ABORT_EN, abort in MULT -> IDLE next cycle, no result_valid, prior results retained.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC definitions: opcode values understood by the MAC stage and the
// sequencer state encoding.
package mac_pkg;

    typedef enum logic [3:0] {
        OP_RESET = 4'h0,
        OP_MULT  = 4'h1,
        OP_ACC   = 4'h2,
        OP_REGA  = 4'h4,
        OP_REGB  = 4'h5,
        OP_MSW   = 4'h6,
        OP_LSW   = 4'h7,
        OP_NOOP  = 4'hF
    } mac_op_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_MULT,
        ST_ACC,
        ST_RD_MSW,
        ST_RD_LSW,
        ST_CAP,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: streams operand pairs into a MAC stage and captures the result.
// Optional feature: define MAC_SEQ_ABORT_EN to add the abort input.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  a_reset_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [3:0]            mac_opcode,
    output logic [DATA_WIDTH-1:0] mac_data,
    input  logic [DATA_WIDTH-1:0] mac_result,
    input  logic                  mac_overflow,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] result_msw,
    output logic [DATA_WIDTH-1:0] result_lsw,
    output logic                  overflow,
    output logic                  result_valid
`ifdef MAC_SEQ_ABORT_EN
    ,
    input  logic                  abort
`endif
);

    seq_state_t            state, state_nxt;
    mac_op_t               op;
    logic [LEN_WIDTH-1:0]  count;
    logic [DATA_WIDTH-1:0] b_hold;
    logic                  abort_now;

`ifdef MAC_SEQ_ABORT_EN
    assign abort_now = abort && (state != ST_IDLE);
`else
    assign abort_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Element counter, B-operand holding register and captured result words.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            count      <= '0;
            b_hold     <= '0;
            result_msw <= '0;
            result_lsw <= '0;
            overflow   <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                count <= length;
            end else if (state == ST_ACC && !abort_now) begin
                count <= count - LEN_WIDTH'(1);
            end
            if (state == ST_LOAD_A && in_valid && !abort_now) begin
                b_hold <= b_data;
            end
            if (state == ST_RD_LSW && !abort_now) begin
                result_msw <= mac_result;
            end
            if (state == ST_CAP && !abort_now) begin
                result_lsw <= mac_result;
                overflow   <= mac_overflow;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        op           = OP_NOOP;
        mac_data     = '0;
        in_ready     = 1'b0;
        busy         = (state != ST_IDLE);
        result_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CLR;
            end
            ST_CLR: begin
                op        = OP_RESET;
                state_nxt = (count != '0) ? ST_LOAD_A : ST_RD_MSW;
            end
            ST_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op        = OP_REGA;
                    mac_data  = a_data;
                    state_nxt = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                op        = OP_REGB;
                mac_data  = b_hold;
                state_nxt = ST_MULT;
            end
            ST_MULT: begin
                op        = OP_MULT;
                state_nxt = ST_ACC;
            end
            ST_ACC: begin
                // count still holds the pre-decrement value here
                op        = OP_ACC;
                state_nxt = (count != LEN_WIDTH'(1)) ? ST_LOAD_A : ST_RD_MSW;
            end
            ST_RD_MSW: begin
                op        = OP_MSW;
                state_nxt = ST_RD_LSW;
            end
            ST_RD_LSW: begin
                op        = OP_LSW;
                state_nxt = ST_CAP;
            end
            ST_CAP: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                result_valid = 1'b1;
                state_nxt    = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (abort_now) begin
            state_nxt    = ST_IDLE;
            op           = OP_NOOP;
            mac_data     = '0;
            in_ready     = 1'b0;
            result_valid = 1'b0;
        end
    end

    assign mac_opcode = op;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer with a behavioural MAC stage attached.
// Covers MAC_SEQ_ABORT_EN when that macro is defined.
module tb_mac_sequencer;
    import mac_pkg::*;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          a_reset_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] length = '0;
    logic [DW-1:0] a_data = '0;
    logic [DW-1:0] b_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    mac_opcode;
    logic [DW-1:0] mac_data;
    logic [DW-1:0] mac_result;
    logic          mac_overflow;
    logic          busy;
    logic [DW-1:0] result_msw;
    logic [DW-1:0] result_lsw;
    logic          overflow;
    logic          result_valid;
    logic          abort = 1'b0;

    always #5 clk = ~clk;

    mac_sequencer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .a_reset_n    (a_reset_n),
        .start        (start),
        .length       (length),
        .a_data       (a_data),
        .b_data       (b_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mac_opcode   (mac_opcode),
        .mac_data     (mac_data),
        .mac_result   (mac_result),
        .mac_overflow (mac_overflow),
        .busy         (busy),
        .result_msw   (result_msw),
        .result_lsw   (result_lsw),
        .overflow     (overflow),
        .result_valid (result_valid)
`ifdef MAC_SEQ_ABORT_EN
        ,
        .abort        (abort)
`endif
    );

    // Behavioural MAC stage: 2*DW accumulator with a sticky carry-out flag.
    logic [DW-1:0]   m_rega, m_regb;
    logic [2*DW-1:0] m_prod, m_acc;
    logic [2*DW:0]   m_sum;
    logic            m_ovf;
    assign m_sum        = {1'b0, m_acc} + {1'b0, m_prod};
    assign mac_overflow = m_ovf;

    always @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            m_rega <= '0; m_regb <= '0; m_prod <= '0; m_acc <= '0; m_ovf <= 1'b0;
            mac_result <= '0;
        end else begin
            case (mac_opcode)
                4'h0: begin m_rega <= '0; m_regb <= '0; m_prod <= '0; m_acc <= '0; m_ovf <= 1'b0; end
                4'h4: m_rega <= mac_data;
                4'h5: m_regb <= mac_data;
                4'h1: m_prod <= {{DW{1'b0}}, m_rega} * {{DW{1'b0}}, m_regb};
                4'h2: begin m_acc <= m_sum[2*DW-1:0]; if (m_sum[2*DW]) m_ovf <= 1'b1; end
                4'h6: mac_result <= m_acc[2*DW-1:DW];
                4'h7: mac_result <= m_acc[DW-1:0];
                default: ;
            endcase
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    int el_a[$], el_b[$], el_st[$];
    logic [3:0]    exp_op[$], obs_op[$];
    logic [DW-1:0] exp_data[$], obs_data[$];
    logic [DW-1:0] exp_msw, exp_lsw, obs_msw, obs_lsw;
    logic          exp_ovf, obs_ovf, post_rv, post_busy;
    int            exp_lat, rv_cyc, rv_count, start_poke_cyc;

    // Reference: opcode/data sequence, result and latency from plain arithmetic.
    task automatic build_expect(input int len);
        longint sum = 0;
        int stalls = 0;
        exp_op.delete(); exp_data.delete();
        exp_op.push_back(4'h0); exp_data.push_back('0);
        for (int e = 0; e < len; e++) begin
            for (int s = 0; s < el_st[e]; s++) begin exp_op.push_back(4'hF); exp_data.push_back('0); end
            exp_op.push_back(4'h4); exp_data.push_back(DW'(el_a[e]));
            exp_op.push_back(4'h5); exp_data.push_back(DW'(el_b[e]));
            exp_op.push_back(4'h1); exp_data.push_back('0);
            exp_op.push_back(4'h2); exp_data.push_back('0);
            sum += longint'(el_a[e]) * longint'(el_b[e]);
            stalls += el_st[e];
        end
        exp_op.push_back(4'h6); exp_data.push_back('0);
        exp_op.push_back(4'h7); exp_data.push_back('0);
        exp_op.push_back(4'hF); exp_data.push_back('0);
        exp_op.push_back(4'hF); exp_data.push_back('0);
        exp_lat = 4 * len + 5 + stalls;
        exp_ovf = (sum >= (longint'(1) << (2 * DW)));
        exp_msw = DW'(sum >> DW);
        exp_lsw = DW'(sum);
    endtask

    task automatic run_dot(input int len);
        int e, stall_left, c;
        build_expect(len);
        obs_op.delete(); obs_data.delete();
        rv_cyc = -1; rv_count = 0;
        @(posedge clk); #1;
        start = 1'b1; length = LW'(len); in_valid = 1'b0;
        @(posedge clk); #1;
        e = 0;
        stall_left = (len > 0) ? el_st[0] : 0;
        c = 1;
        while (c <= exp_lat + 10) begin
            start  = (c == start_poke_cyc);
            length = LW'($urandom);
            if (in_ready === 1'b1 && e < len) begin
                if (stall_left > 0) begin
                    in_valid = 1'b0; stall_left--;
                    a_data = DW'($urandom); b_data = DW'($urandom);
                end else begin
                    in_valid = 1'b1; a_data = DW'(el_a[e]); b_data = DW'(el_b[e]);
                    e++;
                    stall_left = (e < len) ? el_st[e] : 0;
                end
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                a_data = DW'($urandom); b_data = DW'($urandom);
            end
            #1;
            obs_op.push_back(mac_opcode); obs_data.push_back(mac_data);
            if (result_valid === 1'b1) begin
                rv_count++;
                if (rv_cyc < 0) begin
                    rv_cyc = c; obs_msw = result_msw; obs_lsw = result_lsw; obs_ovf = overflow;
                end
            end
            @(posedge clk); #1;
            if (rv_cyc >= 0) break;
            c++;
        end
        start = 1'b0; in_valid = 1'b0; start_poke_cyc = 0;
        #1;
        post_rv = result_valid; post_busy = busy;
    endtask

    task automatic test_reset;
        a_reset_n = 1'b0; start = 1'b1; length = 8'd3;
        @(posedge clk); #2;
        n_cmp++; if (mac_opcode !== 4'hF) begin n_err++; $display("[TB] FAIL reset opcode: got %h expected f", mac_opcode); end
        n_cmp++; if (mac_data !== '0) begin n_err++; $display("[TB] FAIL reset mac_data: got %h expected 00", mac_data); end
        n_cmp++; if ({in_ready, busy, result_valid, overflow} !== 4'b0) begin n_err++; $display("[TB] FAIL reset flags: got %b expected 0000", {in_ready, busy, result_valid, overflow}); end
        n_cmp++; if ({result_msw, result_lsw} !== '0) begin n_err++; $display("[TB] FAIL reset result: got %h expected 0000", {result_msw, result_lsw}); end
        start = 1'b0;
        @(negedge clk); a_reset_n = 1'b1;
    endtask

    task automatic test_single;
        el_a = '{3}; el_b = '{5}; el_st = '{0};
        run_dot(1);
        n_cmp++; if (rv_cyc !== 9) begin n_err++; $display("[TB] FAIL single latency: got %0d expected 9", rv_cyc); end
        n_cmp++; if ({obs_msw, obs_lsw} !== 16'h000F) begin n_err++; $display("[TB] FAIL single result: got %h expected 000f", {obs_msw, obs_lsw}); end
        n_cmp++; if (obs_ovf !== 1'b0) begin n_err++; $display("[TB] FAIL single overflow: got %b expected 0", obs_ovf); end
        n_cmp++; if ({post_rv, post_busy} !== 2'b00) begin n_err++; $display("[TB] FAIL single pulse/busy after done: got %b expected 00", {post_rv, post_busy}); end
    endtask

    task automatic test_saturating;
        el_a = '{255, 255, 255}; el_b = '{255, 255, 255}; el_st = '{0, 0, 0};
        run_dot(3);
        n_cmp++; if ({obs_msw, obs_lsw} !== 16'hFA03) begin n_err++; $display("[TB] FAIL saturating result: got %h expected fa03", {obs_msw, obs_lsw}); end
        n_cmp++; if (obs_ovf !== 1'b1) begin n_err++; $display("[TB] FAIL saturating overflow: got %b expected 1", obs_ovf); end
        n_cmp++; if (rv_cyc !== 17) begin n_err++; $display("[TB] FAIL saturating latency: got %0d expected 17", rv_cyc); end
    endtask

    task automatic test_reset_midrun;
        @(posedge clk); #1; start = 1'b1; length = 8'd2;
        @(posedge clk); #1; start = 1'b0; in_valid = 1'b1; a_data = 8'd7; b_data = 8'd9;
        @(posedge clk); #1;
        @(posedge clk); #1; in_valid = 1'b0;
        #2 a_reset_n = 1'b0;
        #1;
        n_cmp++; if (mac_opcode !== 4'hF) begin n_err++; $display("[TB] FAIL midrun reset opcode: got %h expected f", mac_opcode); end
        n_cmp++; if ({busy, in_ready, result_valid} !== 3'b000) begin n_err++; $display("[TB] FAIL midrun reset flags: got %b expected 000", {busy, in_ready, result_valid}); end
        n_cmp++; if ({result_msw, result_lsw, overflow} !== 17'h0) begin n_err++; $display("[TB] FAIL midrun reset results: got %h expected 0", {result_msw, result_lsw, overflow}); end
        @(negedge clk); a_reset_n = 1'b1;
        el_a = '{3}; el_b = '{5}; el_st = '{0};
        run_dot(1);
        n_cmp++; if ({obs_msw, obs_lsw, obs_ovf} !== {16'h000F, 1'b0}) begin n_err++; $display("[TB] FAIL post-reset run: got %h expected 0001e", {obs_msw, obs_lsw, obs_ovf}); end
        n_cmp++; if (rv_cyc !== 9) begin n_err++; $display("[TB] FAIL post-reset latency: got %0d expected 9", rv_cyc); end
    endtask

    task automatic test_zero_length;
        int bad = -1;
        el_a.delete(); el_b.delete(); el_st.delete();
        run_dot(0);
        for (int i = 0; i < exp_op.size(); i++)
            if (i >= obs_op.size() || obs_op[i] !== exp_op[i]) begin bad = i; break; end
        n_cmp++; if (bad >= 0) begin n_err++; $display("[TB] FAIL zero-length opcode cycle %0d: got %h expected %h", bad + 1, (bad < obs_op.size()) ? obs_op[bad] : 4'hx, exp_op[bad]); end
        n_cmp++; if (rv_cyc !== 5) begin n_err++; $display("[TB] FAIL zero-length latency: got %0d expected 5", rv_cyc); end
        n_cmp++; if ({obs_msw, obs_lsw, obs_ovf} !== 17'h0) begin n_err++; $display("[TB] FAIL zero-length result: got %h expected 0", {obs_msw, obs_lsw, obs_ovf}); end
    endtask

    task automatic test_stall;
        int bad_op = -1, bad_data = -1;
        el_a = '{2, 6}; el_b = '{4, 7}; el_st = '{0, 5};
        run_dot(2);
        for (int i = 0; i < exp_op.size(); i++)
            if (i >= obs_op.size() || obs_op[i] !== exp_op[i]) begin bad_op = i; break; end
        for (int i = 0; i < exp_data.size(); i++)
            if (i >= obs_data.size() || obs_data[i] !== exp_data[i]) begin bad_data = i; break; end
        n_cmp++; if (bad_op >= 0) begin n_err++; $display("[TB] FAIL stall opcode cycle %0d: got %h expected %h", bad_op + 1, (bad_op < obs_op.size()) ? obs_op[bad_op] : 4'hx, exp_op[bad_op]); end
        n_cmp++; if (bad_data >= 0) begin n_err++; $display("[TB] FAIL stall mac_data cycle %0d: got %h expected %h", bad_data + 1, (bad_data < obs_data.size()) ? obs_data[bad_data] : 8'hxx, exp_data[bad_data]); end
        n_cmp++; if (rv_cyc !== 18) begin n_err++; $display("[TB] FAIL stall latency: got %0d expected 18", rv_cyc); end
        n_cmp++; if ({obs_msw, obs_lsw} !== 16'h0032) begin n_err++; $display("[TB] FAIL stall result: got %h expected 0032", {obs_msw, obs_lsw}); end
    endtask

    task automatic test_start_ignored;
        el_a = '{10, 20}; el_b = '{11, 12}; el_st = '{1, 0};
        start_poke_cyc = 4;
        run_dot(2);
        n_cmp++; if (rv_cyc !== exp_lat) begin n_err++; $display("[TB] FAIL start-ignored latency: got %0d expected %0d", rv_cyc, exp_lat); end
        n_cmp++; if ({obs_msw, obs_lsw} !== {exp_msw, exp_lsw}) begin n_err++; $display("[TB] FAIL start-ignored result: got %h expected %h", {obs_msw, obs_lsw}, {exp_msw, exp_lsw}); end
        n_cmp++; if (rv_count !== 1 || post_busy !== 1'b0) begin n_err++; $display("[TB] FAIL start-ignored pulses/busy: got %0d/%b expected 1/0", rv_count, post_busy); end
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            int len = $urandom_range(0, 6);
            int bad = -1;
            el_a.delete(); el_b.delete(); el_st.delete();
            for (int e = 0; e < len; e++) begin
                el_a.push_back($urandom_range(0, 255));
                el_b.push_back($urandom_range(0, 255));
                el_st.push_back($urandom_range(0, 2));
            end
            run_dot(len);
            for (int i = 0; i < exp_op.size(); i++)
                if (i >= obs_op.size() || obs_op[i] !== exp_op[i] || obs_data[i] !== exp_data[i]) begin bad = i; break; end
            n_cmp++; if (bad >= 0) begin n_err++; $display("[TB] FAIL random run %0d op/data cycle %0d: got %h/%h expected %h/%h", r, bad + 1, (bad < obs_op.size()) ? obs_op[bad] : 4'hx, (bad < obs_data.size()) ? obs_data[bad] : 8'hxx, exp_op[bad], exp_data[bad]); end
            n_cmp++; if (rv_cyc !== exp_lat) begin n_err++; $display("[TB] FAIL random run %0d latency: got %0d expected %0d", r, rv_cyc, exp_lat); end
            n_cmp++; if ({obs_msw, obs_lsw, obs_ovf} !== {exp_msw, exp_lsw, exp_ovf}) begin n_err++; $display("[TB] FAIL random run %0d result: got %h expected %h", r, {obs_msw, obs_lsw, obs_ovf}, {exp_msw, exp_lsw, exp_ovf}); end
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            n_cmp++; if ({result_msw, result_lsw, overflow} !== {exp_msw, exp_lsw, exp_ovf}) begin n_err++; $display("[TB] FAIL random run %0d hold: got %h expected %h", r, {result_msw, result_lsw, overflow}, {exp_msw, exp_lsw, exp_ovf}); end
        end
    endtask

`ifdef MAC_SEQ_ABORT_EN
    task automatic test_abort;
        logic [16:0] held;
        int seen_rv = 0;
        bit found = 0;
        held = {result_msw, result_lsw, overflow};
        @(posedge clk); #1; start = 1'b1; length = 8'd2;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; a_data = 8'd9; b_data = 8'd9;
            #1;
            if (mac_opcode === 4'h1) begin found = 1; break; end
            @(posedge clk); #1;
        end
        n_cmp++; if (!found) begin n_err++; $display("[TB] FAIL abort reach MULT: got timeout expected opcode 1"); end
        abort = 1'b1; in_valid = 1'b0;
        #1;
        n_cmp++; if (mac_opcode !== 4'hF) begin n_err++; $display("[TB] FAIL abort opcode: got %h expected f", mac_opcode); end
        @(posedge clk); #1; abort = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort busy: got %b expected 0", busy); end
        for (int k = 0; k < 15; k++) begin
            if (result_valid === 1'b1) seen_rv++;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen_rv !== 0) begin n_err++; $display("[TB] FAIL abort result_valid pulses: got %0d expected 0", seen_rv); end
        n_cmp++; if ({result_msw, result_lsw, overflow} !== held) begin n_err++; $display("[TB] FAIL abort results held: got %h expected %h", {result_msw, result_lsw, overflow}, held); end
    endtask
`endif

    initial begin
        start_poke_cyc = 0;
        test_reset;
        test_single;
        test_saturating;
        test_reset_midrun;
        test_zero_length;
        test_stall;
        test_start_ignored;
        test_random;
`ifdef MAC_SEQ_ABORT_EN
        test_abort;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
